cpu_control_br: RTL and testbench
=================================

# cpu_control_br

Parametrised multicycle control FSM for the Simple RISC Machine, successor to the lab-7 `control` block. Adds conditional and linking branches, LDR/STR with configurable memory wait, and HALT, and drives a PC next-value select. It sits between the instruction register/status flags and the datapath, PC, address register and memory command bus.

## Interface
- `MEM_RD_WAIT`, default 1: cycles memory needs after `mem_cmd`/address are stable before `mdata` is valid (≥1); applies to fetch and LDR.
- `MEM_WR_WAIT`, default 1: cycles `MWRITE` is held for STR (≥1).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 3: IR[15:13]. `op` in 2: IR[12:11]. `cond` in 3: IR[10:8].
- `N`, `V`, `Z` in 1 each: status register outputs.
- `load_ir`, `load_addr`, `load_pc`, `reset_pc`, `addr_sel` out 1: IR, address register, PC enables; PC reset; address mux (1 = PC).
- `pc_sel` out 2: 00 PC+1, 01 PC+1+sximm8, 10 datapath_out.
- `mem_cmd` out 2: 00 MNONE, 01 MREAD, 10 MWRITE.
- `vsel` out 2: 00 mdata, 01 sximm8, 10 PC, 11 C.
- `write`, `loada`, `loadb`, `asel`, `bsel`, `loadc`, `loads` out 1: datapath controls.
- `nsel` out 3: one-hot register select, 100 Rn, 010 Rd, 001 Rm.
- `halted` out 1: high in sHalt.

## Operation
- Moore outputs, decoded from state only; every output not listed for a state is 0 (`nsel` 000, `pc_sel` 00).
- sReset: `reset_pc`, `load_pc` → sIF1.
- sIF1: `addr_sel`, MREAD; held MEM_RD_WAIT cycles via wait counter → sIF2.
- sIF2: `addr_sel`, MREAD, `load_ir` → sUpdatePC.
- sUpdatePC: `load_pc`, `pc_sel`=00 → sDecode.
- sDecode dispatch: 101 ALU → sGetA (op 11 MVN → sGetB); 110 op10 → sMovIm, op00 → sGetB; 011/100 → sGetA; 001 → sIF1 if condition false, else sBranch; 010 → sLink/sBX; 111 and 000 → sHalt.
- Conditions: 000 always, 001 Z, 010 ~Z, 011 N≠V, 100 (N≠V)|Z; 101–111 never taken.
- sGetA: `loada`, nsel Rn. sGetB: `loadb`, nsel Rm. sALU: `loadc`, `asel`=1 for MOV/MVN; `loads` only for CMP (op 01); CMP → sIF1, others → sWriteReg: `write`, vsel C, nsel Rd → sIF1.
- sMovIm: `write`, vsel sximm8, nsel Rn → sIF1.
- LDR/STR: sGetA → sMemAddr (`bsel`, `loadc`) → sLoadAddr (`load_addr`). LDR: sMemRd (MREAD, `addr_sel`=0, MEM_RD_WAIT cycles) → sLdrWr (`write`, vsel mdata, nsel Rd, MREAD held). STR: sStrB (`loadb`, nsel Rd) → sStrC (`asel`, `loadc`) → sStrWr (MWRITE, MEM_WR_WAIT cycles) → sIF1.
- sBranch: `load_pc`, `pc_sel`=01 → sIF1.
- sLink (BL, BLX): `write`, vsel PC, nsel Rn (R7); BL → sBranch; BLX → sBX.
- sBX: sGetB-equivalent `loadb`, nsel Rd → sBXC (`asel`, `loadc`) → sBXPC (`load_pc`, `pc_sel`=10) → sIF1.
- sHalt: `halted`; remains until `reset`.

## Timing
- `reset` sampled at posedge: next state sReset regardless of current state, wait counter cleared; outputs valid the following cycle. Mid-instruction reset abandons the instruction; no `write`/MWRITE issued after it.
- Reset-state outputs: `reset_pc`=1, `load_pc`=1, all others 0, `halted`=0.
- Wait counter loads on state entry, counts down, exits when it reaches 1; MEM_RD_WAIT=1 gives one cycle per wait state.
- Fetch-to-decode: MEM_RD_WAIT+2 cycles. ADD: decode +4 cycles. Taken B: decode +1. Not-taken: decode → sIF1 directly.
- Flags sampled in sDecode only.

## Configuration
- `CTRL_BRANCH_LINK_EN` defined: BL (op 11), BX (op 00), BLX (op 10) on opcode 010 supported as above; other op values → sHalt.
- Not defined: sLink, sBX, sBXC, sBXPC absent; opcode 010 → sHalt; `pc_sel` never 10, `vsel` never 10.

## Structure
- Shared package `cpu_pkg`: state enum, opcode/op/cond encodings, `mem_cmd` MNONE/MREAD/MWRITE, `vsel`, `pc_sel`, `nsel` constants.
- Sub-module `branch_cond`: combinational cond/N/V/Z → `taken`.

## Test plan
- Reset, then ADD R2,R1,R0 (MEM_RD_WAIT=1): reset_pc=1 first cycle; load_ir once; sWriteReg has write=1, vsel=11, nsel=010.
- BEQ with Z=1 → sBranch, load_pc=1, pc_sel=01; Z=0 → sIF1 next cycle, load_pc not asserted.
- BLT with N=1,V=0 taken; N=1,V=1 not taken; BLE with Z=1,N=V taken.
- LDR with MEM_RD_WAIT=3: MREAD with addr_sel=0 for 3 cycles, then write=1, vsel=00; STR MWRITE held MEM_WR_WAIT cycles.
- BL with macro on: write=1, vsel=10, nsel=100 then pc_sel=01; macro off: halted=1 after decode.
- HALT → halted stays 1 for 20 cycles; reset asserted mid-STR → no MWRITE, reset_pc=1 next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the Simple RISC Machine control path: FSM states,
// instruction fields, memory commands and datapath mux selects.
package cpu_pkg;

   typedef enum logic [4:0] {
      S_RESET,
      S_IF1,
      S_IF2,
      S_UPDATE_PC,
      S_DECODE,
      S_GET_A,
      S_GET_B,
      S_ALU,
      S_WRITE_REG,
      S_MOV_IM,
      S_MEM_ADDR,
      S_LOAD_ADDR,
      S_MEM_RD,
      S_LDR_WR,
      S_STR_B,
      S_STR_C,
      S_STR_WR,
      S_BRANCH,
      S_LINK,
      S_BX,
      S_BXC,
      S_BXPC,
      S_HALT
   } state_t;

   localparam logic [2:0] OPC_BRANCH = 3'b001;
   localparam logic [2:0] OPC_BL     = 3'b010;
   localparam logic [2:0] OPC_LDR    = 3'b011;
   localparam logic [2:0] OPC_STR    = 3'b100;
   localparam logic [2:0] OPC_ALU    = 3'b101;
   localparam logic [2:0] OPC_MOV    = 3'b110;
   localparam logic [2:0] OPC_HALT   = 3'b111;

   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_CMP     = 2'b01;
   localparam logic [1:0] OP_AND     = 2'b10;
   localparam logic [1:0] OP_MVN     = 2'b11;
   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_BX      = 2'b00;
   localparam logic [1:0] OP_BLX     = 2'b10;
   localparam logic [1:0] OP_BL      = 2'b11;

   localparam logic [2:0] COND_AL = 3'b000;
   localparam logic [2:0] COND_EQ = 3'b001;
   localparam logic [2:0] COND_NE = 3'b010;
   localparam logic [2:0] COND_LT = 3'b011;
   localparam logic [2:0] COND_LE = 3'b100;

   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   localparam logic [1:0] VSEL_MDATA  = 2'b00;
   localparam logic [1:0] VSEL_SXIMM8 = 2'b01;
   localparam logic [1:0] VSEL_PC     = 2'b10;
   localparam logic [1:0] VSEL_C      = 2'b11;

   localparam logic [1:0] PC_SEL_INC  = 2'b00;
   localparam logic [1:0] PC_SEL_REL  = 2'b01;
   localparam logic [1:0] PC_SEL_DOUT = 2'b10;

   localparam logic [2:0] NSEL_NONE = 3'b000;
   localparam logic [2:0] NSEL_RN   = 3'b100;
   localparam logic [2:0] NSEL_RD   = 3'b010;
   localparam logic [2:0] NSEL_RM   = 3'b001;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: maps the cond field and N/V/Z flags to taken.
module branch_cond
   import cpu_pkg::*;
(
   input  logic [2:0] cond_i,
   input  logic       n_i,
   input  logic       v_i,
   input  logic       z_i,
   output logic       taken_o
);

   always_comb begin
      taken_o = 1'b0;
      case (cond_i)
         COND_AL: taken_o = 1'b1;
         COND_EQ: taken_o = z_i;
         COND_NE: taken_o = ~z_i;
         COND_LT: taken_o = n_i ^ v_i;
         COND_LE: taken_o = (n_i ^ v_i) | z_i;
         default: taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/cpu_control_br.sv
// Multicycle Moore control FSM with branches, LDR/STR memory waits and HALT.
// Define CTRL_BRANCH_LINK_EN to enable BL/BX/BLX on opcode 010.
module cpu_control_br
   import cpu_pkg::*;
#(
   parameter int MEM_RD_WAIT = 1,
   parameter int MEM_WR_WAIT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] opcode,
   input  logic [1:0] op,
   input  logic [2:0] cond,
   input  logic       N,
   input  logic       V,
   input  logic       Z,
   output logic       load_ir,
   output logic       load_addr,
   output logic       load_pc,
   output logic       reset_pc,
   output logic       addr_sel,
   output logic [1:0] pc_sel,
   output logic [1:0] mem_cmd,
   output logic [1:0] vsel,
   output logic       write,
   output logic       loada,
   output logic       loadb,
   output logic       asel,
   output logic       bsel,
   output logic       loadc,
   output logic       loads,
   output logic [2:0] nsel,
   output logic       halted
);

   localparam int WAIT_MAX = (MEM_RD_WAIT > MEM_WR_WAIT) ? MEM_RD_WAIT : MEM_WR_WAIT;
   localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
   localparam logic [WAIT_W-1:0] RD_LOAD  = WAIT_W'(MEM_RD_WAIT);
   localparam logic [WAIT_W-1:0] WR_LOAD  = WAIT_W'(MEM_WR_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              wait_done;
   logic              taken;

   branch_cond u_branch_cond (
      .cond_i  (cond),
      .n_i     (N),
      .v_i     (V),
      .z_i     (Z),
      .taken_o (taken)
   );

   assign wait_done = (wait_q <= WAIT_ONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_RESET;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RESET:     state_d = S_IF1;
         S_IF1:       if (wait_done) state_d = S_IF2;
         S_IF2:       state_d = S_UPDATE_PC;
         S_UPDATE_PC: state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OPC_ALU:          state_d = (op == OP_MVN) ? S_GET_B : S_GET_A;
               OPC_MOV: begin
                  if (op == OP_MOV_IMM)      state_d = S_MOV_IM;
                  else if (op == OP_MOV_REG) state_d = S_GET_B;
                  else                       state_d = S_HALT;
               end
               OPC_LDR, OPC_STR: state_d = S_GET_A;
               OPC_BRANCH:       state_d = taken ? S_BRANCH : S_IF1;
`ifdef CTRL_BRANCH_LINK_EN
               OPC_BL: begin
                  case (op)
                     OP_BL, OP_BLX: state_d = S_LINK;
                     OP_BX:         state_d = S_BX;
                     default:       state_d = S_HALT;
                  endcase
               end
`endif
               default:          state_d = S_HALT;
            endcase
         end
         S_GET_A:     state_d = (opcode == OPC_ALU) ? S_GET_B : S_MEM_ADDR;
         S_GET_B:     state_d = S_ALU;
         S_ALU:       state_d = (opcode == OPC_ALU && op == OP_CMP) ? S_IF1 : S_WRITE_REG;
         S_WRITE_REG: state_d = S_IF1;
         S_MOV_IM:    state_d = S_IF1;
         S_MEM_ADDR:  state_d = S_LOAD_ADDR;
         S_LOAD_ADDR: state_d = (opcode == OPC_LDR) ? S_MEM_RD : S_STR_B;
         S_MEM_RD:    if (wait_done) state_d = S_LDR_WR;
         S_LDR_WR:    state_d = S_IF1;
         S_STR_B:     state_d = S_STR_C;
         S_STR_C:     state_d = S_STR_WR;
         S_STR_WR:    if (wait_done) state_d = S_IF1;
         S_BRANCH:    state_d = S_IF1;
`ifdef CTRL_BRANCH_LINK_EN
         S_LINK:      state_d = (op == OP_BL) ? S_BRANCH : S_BX;
         S_BX:        state_d = S_BXC;
         S_BXC:       state_d = S_BXPC;
         S_BXPC:      state_d = S_IF1;
`endif
         S_HALT:      state_d = S_HALT;
         default:     state_d = S_RESET;
      endcase

      // The wait counter reloads whenever a new state is entered, so a wait
      // state reached from another wait state still gets its full count.
      wait_d = wait_q;
      if (state_d != state_q) begin
         case (state_d)
            S_IF1, S_MEM_RD: wait_d = RD_LOAD;
            S_STR_WR:        wait_d = WR_LOAD;
            default:         wait_d = '0;
         endcase
      end else if (wait_q > WAIT_ONE) begin
         wait_d = wait_q - WAIT_ONE;
      end
   end

   always_comb begin
      load_ir   = 1'b0;
      load_addr = 1'b0;
      load_pc   = 1'b0;
      reset_pc  = 1'b0;
      addr_sel  = 1'b0;
      pc_sel    = PC_SEL_INC;
      mem_cmd   = MNONE;
      vsel      = VSEL_MDATA;
      write     = 1'b0;
      loada     = 1'b0;
      loadb     = 1'b0;
      asel      = 1'b0;
      bsel      = 1'b0;
      loadc     = 1'b0;
      loads     = 1'b0;
      nsel      = NSEL_NONE;
      halted    = 1'b0;
      case (state_q)
         S_RESET: begin
            reset_pc = 1'b1;
            load_pc  = 1'b1;
         end
         S_IF1: begin
            addr_sel = 1'b1;
            mem_cmd  = MREAD;
         end
         S_IF2: begin
            addr_sel = 1'b1;
            mem_cmd  = MREAD;
            load_ir  = 1'b1;
         end
         S_UPDATE_PC: begin
            load_pc = 1'b1;
            pc_sel  = PC_SEL_INC;
         end
         S_GET_A: begin
            loada = 1'b1;
            nsel  = NSEL_RN;
         end
         S_GET_B: begin
            loadb = 1'b1;
            nsel  = NSEL_RM;
         end
         S_ALU: begin
            loadc = 1'b1;
            asel  = (opcode == OPC_MOV) || (opcode == OPC_ALU && op == OP_MVN);
            loads = (opcode == OPC_ALU && op == OP_CMP);
         end
         S_WRITE_REG: begin
            write = 1'b1;
            vsel  = VSEL_C;
            nsel  = NSEL_RD;
         end
         S_MOV_IM: begin
            write = 1'b1;
            vsel  = VSEL_SXIMM8;
            nsel  = NSEL_RN;
         end
         S_MEM_ADDR: begin
            bsel  = 1'b1;
            loadc = 1'b1;
         end
         S_LOAD_ADDR: load_addr = 1'b1;
         S_MEM_RD:    mem_cmd = MREAD;
         S_LDR_WR: begin
            write   = 1'b1;
            vsel    = VSEL_MDATA;
            nsel    = NSEL_RD;
            mem_cmd = MREAD;
         end
         S_STR_B: begin
            loadb = 1'b1;
            nsel  = NSEL_RD;
         end
         S_STR_C: begin
            asel  = 1'b1;
            loadc = 1'b1;
         end
         S_STR_WR: mem_cmd = MWRITE;
         S_BRANCH: begin
            load_pc = 1'b1;
            pc_sel  = PC_SEL_REL;
         end
`ifdef CTRL_BRANCH_LINK_EN
         S_LINK: begin
            write = 1'b1;
            vsel  = VSEL_PC;
            nsel  = NSEL_RN;
         end
         S_BX: begin
            loadb = 1'b1;
            nsel  = NSEL_RD;
         end
         S_BXC: begin
            asel  = 1'b1;
            loadc = 1'b1;
         end
         S_BXPC: begin
            load_pc = 1'b1;
            pc_sel  = PC_SEL_DOUT;
         end
`endif
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cpu_control_br.sv
// Bench for cpu_control_br: per-instruction cycle traces built from the
// instruction-class timing rules, compared against the DUT every cycle.
module tb_cpu_control_br;

   localparam int RD_WAIT = 3;
   localparam int WR_WAIT = 2;
   localparam logic [1:0] M_RD = 2'b01;
   localparam logic [1:0] M_WR = 2'b10;

   typedef struct packed {
      logic       load_ir;
      logic       load_addr;
      logic       load_pc;
      logic       reset_pc;
      logic       addr_sel;
      logic [1:0] pc_sel;
      logic [1:0] mem_cmd;
      logic [1:0] vsel;
      logic       write;
      logic       loada;
      logic       loadb;
      logic       asel;
      logic       bsel;
      logic       loadc;
      logic       loads;
      logic [2:0] nsel;
      logic       halted;
   } outs_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] opcode = '0;
   logic [1:0] op = '0;
   logic [2:0] cond = '0;
   logic       N = 1'b0, V = 1'b0, Z = 1'b0;
   logic       load_ir, load_addr, load_pc, reset_pc, addr_sel;
   logic [1:0] pc_sel, mem_cmd, vsel;
   logic       write, loada, loadb, asel, bsel, loadc, loads, halted;
   logic [2:0] nsel;
   outs_t      obs;

   int checks = 0;
   int errors = 0;
   outs_t exp_q[$];

   cpu_control_br #(.MEM_RD_WAIT(RD_WAIT), .MEM_WR_WAIT(WR_WAIT)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .op(op), .cond(cond),
      .N(N), .V(V), .Z(Z),
      .load_ir(load_ir), .load_addr(load_addr), .load_pc(load_pc),
      .reset_pc(reset_pc), .addr_sel(addr_sel), .pc_sel(pc_sel),
      .mem_cmd(mem_cmd), .vsel(vsel), .write(write), .loada(loada),
      .loadb(loadb), .asel(asel), .bsel(bsel), .loadc(loadc),
      .loads(loads), .nsel(nsel), .halted(halted)
   );

   always #5 clk = ~clk;

   assign obs = {load_ir, load_addr, load_pc, reset_pc, addr_sel, pc_sel, mem_cmd,
                 vsel, write, loada, loadb, asel, bsel, loadc, loads, nsel, halted};

   task automatic check(input string tag, input outs_t got, input outs_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Expected output sequence for one instruction, from fetch to the last
   // cycle before the next fetch (or a run of halted cycles).
   task automatic build(input logic [2:0] opc, input logic [1:0] opv, input logic [2:0] cc,
                        input logic n, input logic v, input logic z, input int hold,
                        output bit halts);
      outs_t o;
      bit    taken;
      bit    bx_seq;
      halts  = 1'b0;
      bx_seq = 1'b0;
      for (int i = 0; i < RD_WAIT; i++) begin
         o = '0; o.addr_sel = 1'b1; o.mem_cmd = M_RD; exp_q.push_back(o);
      end
      o = '0; o.addr_sel = 1'b1; o.mem_cmd = M_RD; o.load_ir = 1'b1; exp_q.push_back(o);
      o = '0; o.load_pc = 1'b1; exp_q.push_back(o);
      o = '0; exp_q.push_back(o);
      case (opc)
         3'b101: begin
            if (opv != 2'b11) begin
               o = '0; o.loada = 1'b1; o.nsel = 3'b100; exp_q.push_back(o);
            end
            o = '0; o.loadb = 1'b1; o.nsel = 3'b001; exp_q.push_back(o);
            o = '0; o.loadc = 1'b1; o.asel = (opv == 2'b11); o.loads = (opv == 2'b01);
            exp_q.push_back(o);
            if (opv != 2'b01) begin
               o = '0; o.write = 1'b1; o.vsel = 2'b11; o.nsel = 3'b010; exp_q.push_back(o);
            end
         end
         3'b110: begin
            if (opv == 2'b10) begin
               o = '0; o.write = 1'b1; o.vsel = 2'b01; o.nsel = 3'b100; exp_q.push_back(o);
            end else if (opv == 2'b00) begin
               o = '0; o.loadb = 1'b1; o.nsel = 3'b001; exp_q.push_back(o);
               o = '0; o.loadc = 1'b1; o.asel = 1'b1; exp_q.push_back(o);
               o = '0; o.write = 1'b1; o.vsel = 2'b11; o.nsel = 3'b010; exp_q.push_back(o);
            end else begin
               halts = 1'b1;
            end
         end
         3'b011, 3'b100: begin
            o = '0; o.loada = 1'b1; o.nsel = 3'b100; exp_q.push_back(o);
            o = '0; o.bsel = 1'b1; o.loadc = 1'b1; exp_q.push_back(o);
            o = '0; o.load_addr = 1'b1; exp_q.push_back(o);
            if (opc == 3'b011) begin
               for (int i = 0; i < RD_WAIT; i++) begin
                  o = '0; o.mem_cmd = M_RD; exp_q.push_back(o);
               end
               o = '0; o.write = 1'b1; o.nsel = 3'b010; o.mem_cmd = M_RD; exp_q.push_back(o);
            end else begin
               o = '0; o.loadb = 1'b1; o.nsel = 3'b010; exp_q.push_back(o);
               o = '0; o.asel = 1'b1; o.loadc = 1'b1; exp_q.push_back(o);
               for (int i = 0; i < WR_WAIT; i++) begin
                  o = '0; o.mem_cmd = M_WR; exp_q.push_back(o);
               end
            end
         end
         3'b001: begin
            case (cc)
               3'd0:    taken = 1'b1;
               3'd1:    taken = (z == 1'b1);
               3'd2:    taken = (z == 1'b0);
               3'd3:    taken = (n != v);
               3'd4:    taken = (n != v) || (z == 1'b1);
               default: taken = 1'b0;
            endcase
            if (taken) begin
               o = '0; o.load_pc = 1'b1; o.pc_sel = 2'b01; exp_q.push_back(o);
            end
         end
         3'b010: begin
`ifdef CTRL_BRANCH_LINK_EN
            if (opv == 2'b01) begin
               halts = 1'b1;
            end else begin
               if (opv != 2'b00) begin
                  o = '0; o.write = 1'b1; o.vsel = 2'b10; o.nsel = 3'b100; exp_q.push_back(o);
               end
               if (opv == 2'b11) begin
                  o = '0; o.load_pc = 1'b1; o.pc_sel = 2'b01; exp_q.push_back(o);
               end else begin
                  bx_seq = 1'b1;
               end
            end
`else
            halts = 1'b1;
`endif
         end
         default: halts = 1'b1;
      endcase
      if (bx_seq) begin
         o = '0; o.loadb = 1'b1; o.nsel = 3'b010; exp_q.push_back(o);
         o = '0; o.asel = 1'b1; o.loadc = 1'b1; exp_q.push_back(o);
         o = '0; o.load_pc = 1'b1; o.pc_sel = 2'b10; exp_q.push_back(o);
      end
      if (halts) begin
         for (int i = 0; i < hold; i++) begin
            o = '0; o.halted = 1'b1; exp_q.push_back(o);
         end
      end
   endtask

   task automatic do_reset();
      outs_t o;
      reset = 1'b1;
      @(posedge clk); #1;
      o = '0; o.reset_pc = 1'b1; o.load_pc = 1'b1;
      check("reset", obs, o);
      reset = 1'b0;
   endtask

   // Runs one instruction (optionally cut short after stop_after cycles) and
   // resets afterwards if it halted or was abandoned.
   task automatic step(input string name, input logic [2:0] opc, input logic [1:0] opv,
                       input logic [2:0] cc, input logic n, input logic v, input logic z,
                       input int hold, input int stop_after);
      bit    halts;
      int    idx;
      outs_t e;
      exp_q.delete();
      build(opc, opv, cc, n, v, z, hold, halts);
      idx = 0;
      while (exp_q.size() > 0 && (stop_after < 0 || idx < stop_after)) begin
         e = exp_q.pop_front();
         @(posedge clk); #1;
         check($sformatf("%s.c%0d", name, idx), obs, e);
         // IR changes only once the previous instruction's states are gone.
         if (idx == 0) begin
            opcode = opc; op = opv; cond = cc; N = n; V = v; Z = z;
         end
         if (idx == RD_WAIT + 3) {N, V, Z} = 3'($urandom);
         idx++;
      end
      $display("instr %s opc=%b op=%b cond=%b nvz=%b%b%b cycles=%0d%s", name, opc, opv, cc,
               n, v, z, idx, (exp_q.size() > 0) ? " cut" : "");
      if (halts || exp_q.size() > 0) do_reset();
   endtask

   initial begin
      do_reset();
      step("add",     3'b101, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 3, -1);
      step("beq_t",   3'b001, 2'b00, 3'b001, 1'b0, 1'b0, 1'b1, 3, -1);
      step("beq_nt",  3'b001, 2'b00, 3'b001, 1'b0, 1'b0, 1'b0, 3, -1);
      step("blt_t",   3'b001, 2'b00, 3'b011, 1'b1, 1'b0, 1'b0, 3, -1);
      step("blt_nt",  3'b001, 2'b00, 3'b011, 1'b1, 1'b1, 1'b0, 3, -1);
      step("ble_t",   3'b001, 2'b00, 3'b100, 1'b1, 1'b1, 1'b1, 3, -1);
      step("bnev",    3'b001, 2'b00, 3'b101, 1'b1, 1'b0, 1'b1, 3, -1);
      step("cmp",     3'b101, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 3, -1);
      step("mvn",     3'b101, 2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 3, -1);
      step("movi",    3'b110, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 3, -1);
      step("movr",    3'b110, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 3, -1);
      step("ldr",     3'b011, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 3, -1);
      step("str",     3'b100, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 3, -1);
      step("bl",      3'b010, 2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 3, -1);
      step("bx",      3'b010, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 3, -1);
      step("blx",     3'b010, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 3, -1);
      step("halt",    3'b111, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 20, -1);
      step("str_rst", 3'b100, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 3, RD_WAIT + 7);
      step("add2",    3'b101, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 3, -1);
      for (int k = 0; k < 120; k++) begin
         logic [2:0] r_opc, r_cc, r_nvz;
         logic [1:0] r_op;
         int         cut;
         r_opc = 3'($urandom_range(0, 7));
         r_op  = 2'($urandom_range(0, 3));
         r_cc  = 3'($urandom_range(0, 7));
         r_nvz = 3'($urandom);
         cut   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, RD_WAIT + 8)) : -1;
         step($sformatf("rnd%0d", k), r_opc, r_op, r_cc, r_nvz[2], r_nvz[1], r_nvz[0], 2, cut);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
